// File: rtl/hilo_unit.sv
// HI/LO write pipeline for the multiply/divide unit.
// Decodes HI/LO writers in EX and stalls EX while a division is in flight.
// Writes pass through MEM and WB shadow stages before they reach the
// architectural HI/LO registers. The youngest pending value is forwarded
// back to EX, separately for each half.
module hilo_unit #(
    parameter logic [63:0] RESET_HILO = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ex_op,
    input  logic [31:0] ex_rs,
    input  logic [63:0] md_result,
    input  logic        md_done,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        ex_stall,
    output logic [63:0] hilo_fwd,
    output logic [31:0] mf_data,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // Instruction codes shared with the rest of the pipeline.
    localparam logic [7:0] INST_NOP   = 8'h00;
    localparam logic [7:0] INST_MUL   = 8'h10;
    localparam logic [7:0] INST_MULT  = 8'h11;
    localparam logic [7:0] INST_MULTU = 8'h12;
    localparam logic [7:0] INST_DIV   = 8'h13;
    localparam logic [7:0] INST_DIVU  = 8'h14;
    localparam logic [7:0] INST_MTHI  = 8'h15;
    localparam logic [7:0] INST_MTLO  = 8'h16;
    localparam logic [7:0] INST_MFHI  = 8'h17;
    localparam logic [7:0] INST_MFLO  = 8'h18;

    logic        is_mult;
    logic        is_div;
    logic        ex_hi_we;
    logic        ex_lo_we;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;

    logic        m_hi_we;
    logic        m_lo_we;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        w_hi_we;
    logic        w_lo_we;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] fwd_hi;
    logic [31:0] fwd_lo;

    // Decode the EX instruction into per-half write enables and data.
    always_comb begin
        is_mult  = (ex_op == INST_MULT) || (ex_op == INST_MULTU);
        is_div   = (ex_op == INST_DIV) || (ex_op == INST_DIVU);
        ex_hi_we = is_mult || is_div || (ex_op == INST_MTHI);
        ex_lo_we = is_mult || is_div || (ex_op == INST_MTLO);
        ex_hi    = (is_mult || is_div) ? md_result[63:32] : ex_rs;
        ex_lo    = (is_mult || is_div) ? md_result[31:0]  : ex_rs;
        // A division holds EX until the divider reports completion.
        ex_stall = is_div && !md_done;
    end

    // Stage registers: MEM -> WB -> architectural HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi_we <= 1'b0;
            m_lo_we <= 1'b0;
            m_hi    <= 32'h0;
            m_lo    <= 32'h0;
            w_hi_we <= 1'b0;
            w_lo_we <= 1'b0;
            w_hi    <= 32'h0;
            w_lo    <= 32'h0;
            hi      <= RESET_HILO[63:32];
            lo      <= RESET_HILO[31:0];
        end else if (mem_stall) begin
            // Frozen, but a flush must still kill the MEM write.
            if (flush) begin
                m_hi_we <= 1'b0;
                m_lo_we <= 1'b0;
            end
        end else begin
            if (w_hi_we) hi <= w_hi;
            if (w_lo_we) lo <= w_lo;
            w_hi_we <= m_hi_we;
            w_lo_we <= m_lo_we;
            w_hi    <= m_hi;
            w_lo    <= m_lo;
            // Stalled or flushed EX contributes a bubble.
            m_hi_we <= ex_hi_we && !ex_stall && !flush;
            m_lo_we <= ex_lo_we && !ex_stall && !flush;
            m_hi    <= ex_hi;
            m_lo    <= ex_lo;
        end
    end

    // Per-half forwarding: MEM beats WB beats architectural.
    always_comb begin
        fwd_hi   = m_hi_we ? m_hi : (w_hi_we ? w_hi : hi);
        fwd_lo   = m_lo_we ? m_lo : (w_lo_we ? w_lo : lo);
        hilo_fwd = {fwd_hi, fwd_lo};
        if (ex_op == INST_MFHI) begin
            mf_data = fwd_hi;
        end else if (ex_op == INST_MFLO) begin
            mf_data = fwd_lo;
        end else begin
            mf_data = 32'h0;
        end
    end

    // Architectural outputs.
    always_comb begin
        hi_o = hi;
        lo_o = lo;
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of pending HI/LO writes.
module tb_hilo_unit;

    localparam logic [63:0] RESET_HILO = 64'h0;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MUL   = 8'h10;
    localparam logic [7:0] OP_MULT  = 8'h11;
    localparam logic [7:0] OP_MULTU = 8'h12;
    localparam logic [7:0] OP_DIV   = 8'h13;
    localparam logic [7:0] OP_DIVU  = 8'h14;
    localparam logic [7:0] OP_MTHI  = 8'h15;
    localparam logic [7:0] OP_MTLO  = 8'h16;
    localparam logic [7:0] OP_MFHI  = 8'h17;
    localparam logic [7:0] OP_MFLO  = 8'h18;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ex_op;
    logic [31:0] ex_rs;
    logic [63:0] md_result;
    logic        md_done;
    logic        mem_stall;
    logic        flush;
    logic        ex_stall;
    logic [63:0] hilo_fwd;
    logic [31:0] mf_data;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    hilo_unit #(
        .RESET_HILO(RESET_HILO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_op    (ex_op),
        .ex_rs    (ex_rs),
        .md_result(md_result),
        .md_done  (md_done),
        .mem_stall(mem_stall),
        .flush    (flush),
        .ex_stall (ex_stall),
        .hilo_fwd (hilo_fwd),
        .mf_data  (mf_data),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an in-flight write list, oldest first, plus HI/LO.
    typedef struct packed {
        bit        hw;
        bit        lw;
        bit [31:0] h;
        bit [31:0] l;
    } wr_t;

    wr_t       pend[$];
    bit [31:0] arch_hi;
    bit [31:0] arch_lo;

    function automatic void model_reset();
        wr_t b;
        b = '0;
        pend.delete();
        pend.push_back(b);
        pend.push_back(b);
        arch_hi = RESET_HILO[63:32];
        arch_lo = RESET_HILO[31:0];
    endfunction

    function automatic bit model_stall();
        return ((ex_op == OP_DIV) || (ex_op == OP_DIVU)) && !md_done;
    endfunction

    function automatic bit [31:0] model_fwd(input bit want_hi);
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (want_hi && pend[i].hw) return pend[i].h;
            if (!want_hi && pend[i].lw) return pend[i].l;
        end
        return want_hi ? arch_hi : arch_lo;
    endfunction

    function automatic bit [31:0] model_mf();
        if (ex_op == OP_MFHI) return model_fwd(1'b1);
        if (ex_op == OP_MFLO) return model_fwd(1'b0);
        return 32'h0;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    function automatic void model_edge();
        wr_t n;
        wr_t old;
        bit  md_op;
        n = '0;
        if (mem_stall) begin
            if (flush) begin
                pend[pend.size() - 1].hw = 1'b0;
                pend[pend.size() - 1].lw = 1'b0;
            end
            return;
        end
        old = pend.pop_front();
        if (old.hw) arch_hi = old.h;
        if (old.lw) arch_lo = old.l;
        md_op = (ex_op == OP_MULT) || (ex_op == OP_MULTU) ||
                (ex_op == OP_DIV) || (ex_op == OP_DIVU);
        if (!flush && !model_stall()) begin
            if (md_op) begin
                n.hw = 1'b1;
                n.lw = 1'b1;
                n.h  = md_result[63:32];
                n.l  = md_result[31:0];
            end else if (ex_op == OP_MTHI) begin
                n.hw = 1'b1;
                n.h  = ex_rs;
            end else if (ex_op == OP_MTLO) begin
                n.lw = 1'b1;
                n.l  = ex_rs;
            end
        end
        pend.push_back(n);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check_eq("ex_stall", {63'h0, ex_stall}, {63'h0, model_stall()});
        check_eq("hilo_fwd", hilo_fwd, {model_fwd(1'b1), model_fwd(1'b0)});
        check_eq("mf_data", {32'h0, mf_data}, {32'h0, model_mf()});
        check_eq("hi_o", {32'h0, hi_o}, {32'h0, arch_hi});
        check_eq("lo_o", {32'h0, lo_o}, {32'h0, arch_lo});
    endtask

    // One cycle: drive inputs just after an edge, check before the next one.
    task automatic step(input logic [7:0] op, input logic [31:0] rs, input logic [63:0] res,
                        input logic done, input logic ms, input logic fl);
        ex_op     = op;
        ex_rs     = rs;
        md_result = res;
        md_done   = done;
        mem_stall = ms;
        flush     = fl;
        #2;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic nop();
        step(OP_NOP, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int          stall_cnt;
        logic [7:0]  ops [10];
        logic [7:0]  op;
        logic [31:0] hold_hi;

        ops = '{OP_NOP, OP_MUL, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO};
        rst_n     = 1'b0;
        ex_op     = OP_NOP;
        ex_rs     = 32'h0;
        md_result = 64'h0;
        md_done   = 1'b0;
        mem_stall = 1'b0;
        flush     = 1'b0;
        model_reset();

        // Reset state.
        #2;
        check_eq("rst_hi", {32'h0, hi_o}, 64'h0);
        check_eq("rst_lo", {32'h0, lo_o}, 64'h0);
        check_eq("rst_stall", {63'h0, ex_stall}, 64'h0);
        check_eq("rst_fwd", hilo_fwd, 64'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MULT write-back, then MFHI reads via the MEM forward.
        step(OP_MULT, 32'h0, 64'h00000001_FFFFFFFE, 1'b1, 1'b0, 1'b0);
        ex_op = OP_MFHI;
        #1;
        check_eq("mult_mf_fwd", {32'h0, mf_data}, 64'h1);
        step(OP_MFHI, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        nop();
        check_eq("mult_hi", {32'h0, hi_o}, 64'h1);
        check_eq("mult_lo", {32'h0, lo_o}, 64'hFFFFFFFE);

        // Division stall for 36 cycles, then completion.
        stall_cnt = 0;
        for (int i = 0; i < 36; i++) begin
            ex_op   = OP_DIV;
            md_done = 1'b0;
            #1;
            if (ex_stall) stall_cnt++;
            step(OP_DIV, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("div_stall_cycles", 64'(stall_cnt), 64'd36);
        step(OP_DIV, 32'h0, {32'd2, 32'd7}, 1'b1, 1'b0, 1'b0);
        nop();
        nop();
        check_eq("div_hi", {32'h0, hi_o}, 64'd2);
        check_eq("div_lo", {32'h0, lo_o}, 64'd7);

        // Split forward: MTHI then MTLO merge into one forward.
        step(OP_MTHI, 32'hAAAA0000, 64'h0, 1'b0, 1'b0, 1'b0);
        step(OP_MTLO, 32'h0000BBBB, 64'h0, 1'b0, 1'b0, 1'b0);
        ex_op = OP_MFLO;
        #1;
        check_eq("split_fwd", hilo_fwd, 64'hAAAA0000_0000BBBB);
        check_eq("split_mflo", {32'h0, mf_data}, 64'h0000BBBB);
        step(OP_MFLO, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        nop();
        nop();

        // Flush: younger MTLO dropped, older MTHI in WB still commits.
        step(OP_MTHI, 32'd9, 64'h0, 1'b0, 1'b0, 1'b0);
        nop();
        step(OP_MTLO, 32'd5, 64'h0, 1'b0, 1'b0, 1'b1);
        nop();
        nop();
        check_eq("flush_hi", {32'h0, hi_o}, 64'd9);
        check_eq("flush_lo", {32'h0, lo_o}, 64'h0000BBBB);

        // Downstream stall holds a MULT in MEM.
        step(OP_MULTU, 32'h0, 64'h12345678_9ABCDEF0, 1'b1, 1'b0, 1'b0);
        hold_hi = hi_o;
        for (int i = 0; i < 3; i++) begin
            step(OP_NOP, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
            check_eq("hold_hi", {32'h0, hi_o}, {32'h0, hold_hi});
        end
        nop();
        check_eq("hold_hi_pre", {32'h0, hi_o}, {32'h0, hold_hi});
        nop();
        check_eq("hold_hi_commit", {32'h0, hi_o}, 64'h12345678);
        check_eq("hold_lo_commit", {32'h0, lo_o}, 64'h9ABCDEF0);

        // Reset in the middle of a division with writes in flight.
        step(OP_MTHI, 32'hDEAD0001, 64'h0, 1'b0, 1'b0, 1'b0);
        step(OP_DIVU, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_hi", {32'h0, hi_o}, {32'h0, RESET_HILO[63:32]});
        check_eq("midrst_lo", {32'h0, lo_o}, {32'h0, RESET_HILO[31:0]});
        check_eq("midrst_fwd", hilo_fwd, RESET_HILO);
        #1 rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 9)];
            step(op, $urandom, {$urandom, $urandom},
                 (op == OP_MULT || op == OP_MULTU) ? 1'b1 : 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
